// File: rtl/board_pkg.sv
// Shared constants and FSM state type for the board UART demo.
package board_pkg;

    localparam int CLK_FREQ_DEF    = 50_000_000;
    localparam int BAUD_DEF        = 115_200;
    localparam int TX_INTERVAL_DEF = 50_000;

    function automatic int bit_clks(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    localparam int BIT_CLKS_DEF = bit_clks(CLK_FREQ_DEF, BAUD_DEF);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_st_e;

endpackage

// File: rtl/board_if.sv
// Received-byte bundle from the UART receiver to the board logic.
interface board_if;

    logic [7:0] data;
    logic       valid;

    modport master (output data, output valid);
    modport slave  (input data, input valid);

endinterface

// File: rtl/board_uart_rx.sv
// 8N1 UART receiver: synchronizer, edge detect and centre-sampling FSM.
module uart_rx
    import board_pkg::*;
#(
    parameter int BIT_CLKS = BIT_CLKS_DEF
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     rx_i,
    board_if.master  rx_o
);

    localparam int HALF = BIT_CLKS / 2;
    localparam int BW   = $clog2(BIT_CLKS);

    // [0] first stage, [1] synchronized, [2] previous synchronized
    logic [2:0] sync_d;
    logic [2:0] sync_q;
    logic       rx_s;
    logic       fall;

    always_comb begin
        sync_d = {sync_q[1:0], rx_i};
        rx_s   = sync_q[1];
        fall   = sync_q[2] & ~sync_q[1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    uart_st_e      st_q;
    logic [BW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    sh_q;
    logic [7:0]    data_q;
    logic          valid_q;
    logic          bit_end;
    logic          half_end;

    assign bit_end  = cnt_q == BW'(BIT_CLKS - 1);
    assign half_end = cnt_q == BW'(HALF - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q    <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            cnt_q   <= cnt_q + 1'b1;
            unique case (st_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (fall) st_q <= ST_START;
                end
                ST_START: begin
                    if (half_end) begin
                        cnt_q <= '0;
                        bit_q <= '0;
                        st_q  <= rx_s ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        sh_q  <= {rx_s, sh_q[7:1]};
                        bit_q <= bit_q + 3'd1;
                        if (bit_q == 3'd7) st_q <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        st_q  <= ST_IDLE;
                        // framing errors leave the last good byte untouched
                        if (rx_s) begin
                            data_q  <= sh_q;
                            valid_q <= 1'b1;
                        end
                    end
                end
                default: st_q <= ST_IDLE;
            endcase
        end
    end

    assign rx_o.data  = data_q;
    assign rx_o.valid = valid_q;

endmodule

// File: rtl/board_top.sv
// Board demo: periodic UART TX of a byte counter, RX low six bits to LEDs.
module board_top
    import board_pkg::*;
#(
    parameter int CLK_FREQ    = CLK_FREQ_DEF,
    parameter int BAUD        = BAUD_DEF,
    parameter int TX_INTERVAL = TX_INTERVAL_DEF
) (
    input  logic       clk_50m,
    input  logic       reset_n,
    output logic [5:0] led,
    output logic       uart_tx_path,
    input  logic       uart_rx_path
);

    localparam int BIT_CLKS = bit_clks(CLK_FREQ, BAUD);
    localparam int IW       = $clog2(TX_INTERVAL);
    localparam int BW       = $clog2(BIT_CLKS);

    uart_st_e      tx_st_q;
    logic [BW-1:0] tx_cnt_q;
    logic [2:0]    tx_bit_q;
    logic [7:0]    tx_sh_q;
    logic          tx_q;
    logic          tx_bit_end;

    logic [IW-1:0] int_cnt_d, int_cnt_q;
    logic [7:0]    byte_d, byte_q;
    logic          start_req;
    logic          start_ok;

    always_comb begin
        start_req = int_cnt_q == IW'(TX_INTERVAL - 1);
        start_ok  = start_req && (tx_st_q == ST_IDLE);
        int_cnt_d = start_req ? '0 : int_cnt_q + 1'b1;
        byte_d    = start_ok ? byte_q + 8'd1 : byte_q;
    end

    always_ff @(posedge clk_50m) begin
        if (reset_n) begin
            int_cnt_q <= '0;
            byte_q    <= '0;
        end else begin
            int_cnt_q <= int_cnt_d;
            byte_q    <= byte_d;
        end
    end

    assign tx_bit_end = tx_cnt_q == BW'(BIT_CLKS - 1);

    always_ff @(posedge clk_50m) begin
        if (reset_n) begin
            tx_st_q  <= ST_IDLE;
            tx_cnt_q <= '0;
            tx_bit_q <= '0;
            tx_sh_q  <= '0;
            tx_q     <= 1'b1;
        end else begin
            tx_cnt_q <= tx_bit_end ? '0 : tx_cnt_q + 1'b1;
            unique case (tx_st_q)
                ST_IDLE: begin
                    tx_cnt_q <= '0;
                    if (start_ok) begin
                        tx_st_q <= ST_START;
                        tx_sh_q <= byte_q;
                        tx_q    <= 1'b0;
                    end
                end
                ST_START: begin
                    if (tx_bit_end) begin
                        tx_st_q  <= ST_DATA;
                        tx_bit_q <= '0;
                        tx_q     <= tx_sh_q[0];
                    end
                end
                ST_DATA: begin
                    if (tx_bit_end) begin
                        if (tx_bit_q == 3'd7) begin
                            tx_st_q <= ST_STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            tx_sh_q  <= {1'b0, tx_sh_q[7:1]};
                            tx_bit_q <= tx_bit_q + 3'd1;
                            tx_q     <= tx_sh_q[1];
                        end
                    end
                end
                ST_STOP: begin
                    if (tx_bit_end) tx_st_q <= ST_IDLE;
                end
                default: tx_st_q <= ST_IDLE;
            endcase
        end
    end

    assign uart_tx_path = tx_q;

    board_if rx_if ();

    uart_rx #(
        .BIT_CLKS (BIT_CLKS)
    ) u_rx (
        .clk  (clk_50m),
        .rst  (reset_n),
        .rx_i (uart_rx_path),
        .rx_o (rx_if)
    );

    logic [5:0] led_d, led_q;
    logic       rx_hi_unused;

    always_comb begin
        led_d        = rx_if.valid ? rx_if.data[5:0] : led_q;
        rx_hi_unused = ^rx_if.data[7:6];
    end

    always_ff @(posedge clk_50m) begin
        if (reset_n) begin
            led_q <= '0;
        end else begin
            led_q <= led_d;
        end
    end

    assign led = led_q;

endmodule

// File: tb/tb_board_top.sv
// Bench for board_top: frame-level TX/LED model plus directed RX vectors.
module tb_board_top;

    localparam int CLK_FREQ = 2_000_000;
    localparam int BAUD     = 100_000;
    localparam int BIT      = CLK_FREQ / BAUD;
    localparam int TI       = 210;

    logic       clk;
    logic       reset_n;
    logic [5:0] led;
    logic       tx_line;
    logic       rx_line;
    logic       lb;
    logic       drv;

    int n;
    int in_rst;
    int n_cmp;
    int n_bad;

    board_if mdl_if ();

    assign rx_line = lb ? tx_line : drv;

    board_top #(
        .CLK_FREQ    (CLK_FREQ),
        .BAUD        (BAUD),
        .TX_INTERVAL (TI)
    ) dut (
        .clk_50m      (clk),
        .reset_n      (reset_n),
        .led          (led),
        .uart_tx_path (tx_line),
        .uart_rx_path (rx_line)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // n = clock edges seen since reset was last released
    always @(posedge clk) begin
        if (reset_n) begin
            n      <= 0;
            in_rst <= 1;
        end else begin
            n      <= n + 1;
            in_rst <= 0;
        end
    end

    // Frame k (k>=1) starts n=k*TI and carries byte k-1.
    function automatic logic tx_exp(input int t);
        int k;
        int off;
        logic [7:0] b;
        if (t < TI) return 1'b1;
        k   = t / TI;
        off = t - k * TI;
        b   = 8'(k - 1);
        if (off < BIT) return 1'b0;
        if (off < 9 * BIT) return b[off / BIT - 1];
        return 1'b1;
    endfunction

    function automatic logic led_cares(input int t);
        int off;
        if (t < TI) return 1'b1;
        off = t % TI;
        return !(off >= 9 * BIT && off <= 10 * BIT);
    endfunction

    function automatic logic [5:0] led_exp(input int t);
        int k;
        if (t < TI + 10 * BIT) return 6'd0;
        k = (t - 10 * BIT) / TI;
        return 6'(k - 1);
    endfunction

    task automatic cmp(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got %0h, expected %0h (n=%0d)",
                         nm, act, exp, n);
        end
    endtask

    always @(negedge clk) begin
        if (in_rst != 0) begin
            cmp("reset_tx", tx_line, 1);
            cmp("reset_led", led, 0);
        end else begin
            mdl_if.data  = {2'b00, led_exp(n)};
            mdl_if.valid = lb && led_cares(n);
            cmp("tx_line", tx_line, tx_exp(n));
            if (mdl_if.valid) cmp("led_model", led, mdl_if.data[5:0]);
        end
    end

    task automatic go_to(input int target);
        int guard;
        guard = 0;
        while (n < target && guard < 100000) begin
            @(negedge clk);
            guard++;
        end
        if (n < target) begin
            n_cmp++;
            n_bad++;
            $display("FAIL go_to: n=%0d, expected %0d", n, target);
        end
    endtask

    task automatic send_bit(input logic b);
        drv = b;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
        drv = 1'b1;
        repeat (2 * BIT) @(negedge clk);
    endtask

    initial begin
        #1_500_000;
        n_cmp++;
        n_bad++;
        $display("FAIL watchdog: time %0t, expected finish", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        n       = 0;
        in_rst  = 1;
        lb      = 1'b1;
        drv     = 1'b1;
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        reset_n = 1'b0;

        go_to(TI - 1);
        cmp("pre_first_start", tx_line, 1);
        go_to(TI);
        cmp("first_start_bit", tx_line, 0);
        go_to(TI + 10 * BIT);
        cmp("first_stop_bit", tx_line, 1);
        go_to(TI + 205);
        cmp("led_after_0x00", led, 6'h00);

        go_to(6 * TI + 205);
        cmp("led_after_0x05", led, 6'b000101);
        go_to(64 * TI + 205);
        cmp("led_after_0x3f", led, 6'h3F);
        go_to(65 * TI + 205);
        cmp("led_after_0x40", led, 6'h00);
        go_to(256 * TI + 205);
        cmp("led_after_0xff", led, 6'h3F);
        go_to(257 * TI + 205);
        cmp("led_wrap_0x00", led, 6'h00);
        go_to(258 * TI + 205);
        cmp("led_after_0x01", led, 6'h01);

        // data bit 3 of frame 259 (byte 0x02)
        go_to(259 * TI + 4 * BIT + 5);
        cmp("pre_rst_tx", tx_line, 0);
        cmp("pre_rst_led", led, 6'h01);
        reset_n = 1'b1;
        @(negedge clk);
        cmp("mid_rst_tx", tx_line, 1);
        cmp("mid_rst_led", led, 6'h00);
        repeat (2) @(negedge clk);
        reset_n = 1'b0;

        go_to(TI - 1);
        cmp("restart_idle", tx_line, 1);
        go_to(TI);
        cmp("restart_start", tx_line, 0);
        go_to(2 * TI + 205);
        cmp("restart_led", led, 6'h01);

        lb = 1'b0;
        @(negedge clk);
        drv = 1'b0;
        repeat (4) @(negedge clk);
        drv = 1'b1;
        repeat (3 * BIT) @(negedge clk);
        cmp("rx_glitch", led, 6'h01);

        send_frame(8'hA5, 1'b0);
        cmp("rx_framing_err", led, 6'h01);

        send_frame(8'h2A, 1'b1);
        cmp("rx_valid_2a", led, 6'h2A);

        send_frame(8'hC7, 1'b1);
        cmp("rx_valid_c7", led, 6'h07);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/board_top.md
# board_top

Top-level demo design for the FPGA board: a fixed-rate UART transmitter that sends an incrementing byte counter, and a UART receiver that shows the low six bits of each valid received byte on six LEDs. It sits directly on the board pins (50 MHz oscillator, reset, LEDs, UART TX/RX). In system tests, TX is looped back to RX externally.

## Interface
Parameters:
- CLK_FREQ, 50_000_000: input clock frequency in Hz.
- BAUD, 115_200: UART bit rate. Bit period BIT_CLKS = CLK_FREQ/BAUD, truncated (434).
- TX_INTERVAL, 50_000: clocks between TX frame starts (1 ms). Must be ≥ 10·BIT_CLKS + 1.

Ports:
- clk_50m  in  1  system clock; the single clock domain.
- reset_n  in  1  synchronous, active-high reset (asserted when 1; despite the suffix, polarity is high).
- led  out  6  LED drive, active-high; low six bits of the last valid received byte.
- uart_tx_path  out  1  UART serial output, idle high.
- uart_rx_path  in  1  UART serial input, asynchronous to clk_50m.

## Operation
- Frame format: 8N1. One start bit (0), eight data bits LSB first, one stop bit (1). Each bit lasts BIT_CLKS clocks.
- Transmit scheduler:
  - Free-running interval counter runs 0..TX_INTERVAL-1.
  - When it wraps, it loads the byte counter into the TX shifter and starts a frame.
  - After each frame starts, the byte counter increments mod 256 (0xFF→0x00).
- TX FSM states: IDLE → START → DATA(8 bits) → STOP → IDLE.
  - The line is driven from a register (glitch-free).
  - A start request is ignored if the FSM is not in IDLE. The TX_INTERVAL constraint prevents this case.
- RX input conditioning: two-flop synchronizer on uart_rx_path, plus one extra flop for falling-edge detection.
- RX FSM states: IDLE → START → DATA → STOP → IDLE.
  - IDLE: a synchronized falling edge moves to START.
  - START: waits BIT_CLKS/2 clocks, then re-samples. If the line is high (glitch), return to IDLE. If low, go to DATA.
  - DATA: samples each bit at the bit centre (every BIT_CLKS clocks) and shifts it in LSB first.
  - STOP: samples at the stop-bit centre. If 1, led ← data[5:0]. If 0 (framing error), led is unchanged and the byte is discarded. Either way, return to IDLE.
- No parity, no FIFO. Only the most recent valid byte is kept.

## Timing
- Reset values: led = 6'b000000, uart_tx_path = 1, both FSMs IDLE, byte counter = 0x00, interval counter = 0, all synchronizer flops = 1.
- First TX start bit drives the line on the clock after the interval counter reaches TX_INTERVAL-1 post-reset, i.e. cycle TX_INTERVAL ±1.
- TX frame length: exactly 10·BIT_CLKS clocks (4340). uart_tx_path returns high at the end of the stop bit.
- RX latency: led updates 2 (sync) + 1 (edge) + 9·BIT_CLKS + BIT_CLKS/2 clocks after the RX start-bit falling edge (≈4126 cycles). This is within one bit period of the frame end.
- Reset asserted mid-frame:
  - Next clock: TX line high, FSMs IDLE, counters cleared.
  - A partially received byte is dropped and led returns to 0.
- A low pulse shorter than BIT_CLKS/2 clocks on RX is rejected in START with no side effects.

## Structure
- Shared package `board_pkg`: CLK_FREQ/BAUD defaults, derived BIT_CLKS, and the RX/TX state enum (IDLE, START, DATA, STOP).
- One natural sub-module: `uart_rx` (synchronizer + RX FSM, outputs data[7:0] and valid).
- TX FSM, scheduler, and LED register stay in board_top.

## Test plan
- Reset: hold reset_n=1 for 5 cycles → led=0, uart_tx_path=1 throughout, with no transitions before cycle ~50000 after release.
- Loopback, first frame: TX↔RX tied → frame at cycle ~50000 carries 0x00 (start 0, eight 0s, stop 1, 434 clocks each) → led stays 0x00.
- Loopback, sequence: run 10 ms → frames at 1 ms spacing carry 0x00..0x08 → after frame n completes, led = n; after the frame with 0x05, led = 6'b000101.
- Wrap: preload or run to byte 0xFF → led = 6'h3F. Next byte 0x00 → led = 6'h00. Byte 0x40 → led = 6'h00 (bit 6 dropped).
- RX robustness: drive RX directly with a 100-clock low glitch → led unchanged. Drive a frame 0xA5 with stop=0 → led unchanged. Drive a valid frame 0x2A → led = 6'h2A.
- Reset mid-frame: assert reset_n during data bit 3 of a TX frame → next cycle uart_tx_path=1 and led=0. After release, a fresh frame with byte 0x00 starts after TX_INTERVAL clocks.
